// File: rtl/lifo_stack_if.sv
// Stack port between the processor (master) and lifo_stack (slave).
// Carries push/pop strobes, write data, top-of-stack data and status.
interface lifo_stack_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 5
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             push_err;
    logic             pop_err;

    modport master (
        output push, pop, data_in,
        input  data_out, full, empty, count, push_err, pop_err
    );

    modport slave (
        input  push, pop, data_in,
        output data_out, full, empty, count, push_err, pop_err
    );
endinterface

// File: rtl/lifo_stack.sv
// LIFO stack with synchronous-write storage and show-ahead top-of-stack output.
// Optional sticky error flags are built only when LIFO_STACK_ERR_FLAGS_EN is defined.
module lifo_stack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input logic         clk,
    input logic         resetN,
    lifo_stack_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] sp_q, sp_d;
    logic [AW-1:0]    top_idx, wr_idx;
    logic             wr_en;
    logic             empty, full;

    assign empty   = (sp_q == '0);
    assign full    = (sp_q == CNT_W'(DEPTH));
    assign top_idx = AW'(sp_q - CNT_W'(1));

    always_comb begin
        sp_d   = sp_q;
        wr_en  = 1'b0;
        wr_idx = AW'(sp_q);
        case ({bus.push, bus.pop})
            2'b11: begin
                // Simultaneous push/pop replaces the top; on empty only the push survives.
                wr_en = 1'b1;
                if (empty) begin
                    wr_idx = '0;
                    sp_d   = CNT_W'(1);
                end else begin
                    wr_idx = top_idx;
                end
            end
            2'b10: begin
                if (!full) begin
                    wr_en = 1'b1;
                    sp_d  = sp_q + CNT_W'(1);
                end
            end
            2'b01: begin
                if (!empty) sp_d = sp_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) sp_q <= '0;
        else         sp_q <= sp_d;
    end

    // Storage is intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (resetN && wr_en) mem[wr_idx] <= bus.data_in;
    end

    assign bus.data_out = empty ? '0 : mem[top_idx];
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = sp_q;

`ifdef LIFO_STACK_ERR_FLAGS_EN
    logic push_err_q, pop_err_q;
    logic push_ovf, pop_unf;

    assign push_ovf = bus.push && !bus.pop && full;
    assign pop_unf  = bus.pop && empty;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            push_err_q <= 1'b0;
            pop_err_q  <= 1'b0;
        end else begin
            if (push_ovf) push_err_q <= 1'b1;
            if (pop_unf)  pop_err_q  <= 1'b1;
        end
    end

    assign bus.push_err = push_err_q;
    assign bus.pop_err  = pop_err_q;
`else
    assign bus.push_err = 1'b0;
    assign bus.pop_err  = 1'b0;
`endif
endmodule

// File: doc/lifo_stack.md
# lifo_stack

Hardware LIFO stack serving as the responder end of the processor's stack interface: the multicycle processor drives push/pop strobes and write data, and this block returns top-of-stack data plus full/empty status. Storage is a synchronous-write register array with a show-ahead (combinational) top-of-stack output. This timing lets the processor assert pop in one state and capture the popped word at the end of that same state.

## Interface
Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 16: number of entries; must satisfy 2 ≤ DEPTH ≤ 2^CNT_W − 1.
- CNT_W, 5: width of the occupancy counter and `count` port.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- resetN  in  1  synchronous, active-low reset.
- push  in  1  push strobe; one entry is written per cycle while high.
- pop  in  1  pop strobe; one entry is removed per cycle while high.
- data_in  in  WIDTH  word to push (processor's stack_data_out).
- data_out  out  WIDTH  current top of stack (processor's stack_data_in); combinational.
- full  out  1  high when count == DEPTH.
- empty  out  1  high when count == 0.
- count  out  CNT_W  number of valid entries.
- push_err  out  1  sticky: push attempted while full with no pop (see Configuration).
- pop_err  out  1  sticky: pop attempted while empty (see Configuration).

## Operation
- Internal state: mem[0..DEPTH−1], sp (= count) pointing to the next free slot. The top entry is mem[sp−1].
- data_out = mem[sp−1] when not empty; all zeros when empty.
- The action at each rising edge (resetN high) is chosen from the sampled push, pop, empty and full:
  - push only, not full: mem[sp] ← data_in; sp ← sp+1.
  - push only, full: ignored; contents unchanged; push_err ← 1.
  - pop only, not empty: sp ← sp−1. The memory word is left stale.
  - pop only, empty: ignored; pop_err ← 1.
  - push and pop, not empty: replace top: mem[sp−1] ← data_in; sp unchanged. This also applies when full and is not an error.
  - push and pop, empty: the push is performed (mem[0] ← data_in, sp ← 1); the pop is discarded; pop_err ← 1.
  - neither: hold.
- full and empty decode combinationally from sp. They are never both high.
- sp never wraps: it saturates at 0 and at DEPTH because of the ignore rules above.
- Arithmetic is unsigned, CNT_W bits. There is no ALU behaviour in this block.

## Timing
- Reset (resetN low at an edge, overriding push/pop): sp=0, count=0, empty=1, full=0, data_out=0, push_err=0, pop_err=0. Memory contents are not cleared.
- Reset asserted mid-sequence discards all entries at that edge. Strobes sampled in the same cycle have no effect.
- Write latency: a word pushed at edge N is visible on data_out after edge N, i.e. during cycle N+1.
- Pop latency: data_out shows the word being popped during the cycle pop is high. After the edge, data_out shows the next-lower entry. Back-to-back pops therefore deliver successive entries each cycle with no bubbles.
- Strobes are level-sampled every cycle. Holding push or pop high for k cycles performs k operations. No acknowledge is returned; the initiator must observe full and empty.
- count, full and empty update at the same edge as the operation.

## Configuration
- Macro LIFO_STACK_ERR_FLAGS_EN.
- When defined: push_err and pop_err are sticky registers, set as described in Operation and cleared only by reset.
- When undefined: the error registers are not built; push_err and pop_err are tied to 0. Ignore behaviour on full and empty is identical in both builds.

## Test plan
- Reset with DEPTH=16: after resetN low for 1 edge, check empty=1, full=0, count=0, data_out=0x00, both error flags 0.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 cycles. Sampled data_out during the pop cycles must be 0x33, 0x22, 0x11; afterwards empty=1.
- Fill with 16 pushes: full=1, count=16. A 17th push with value 0xAA is ignored: top stays at the 16th value and push_err=1 (flag only when the macro is defined).
- Pop while empty: count stays 0 and pop_err=1. Then push and pop together while empty with data_in=0x5C: count=1, data_out=0x5C, pop_err stays 1.
- With count=4 and top 0x40, assert push and pop together with data_in=0x99: count stays 4, data_out=0x99. Repeat at full: full stays 1, no push_err.
- With count=5, assert resetN low in the same cycle as push: afterwards count=0 and empty=1. Push 0x01: data_out=0x01, count=1.
